// File: rtl/gpu_text_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// gpu_text_cmd_sequencer : CPU text-command sequencer sharing char RAM with scanout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpu_text_cmd_sequencer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [15:0]       cpu_data,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE_OP    = 2'd0,
    S_IDLE_PARAM = 2'd1,
    S_EXEC       = 2'd2,
    S_CLEAR      = 2'd3
  } state_t;

  localparam logic [5:0]        c_x_max = 6'(COLS - 1);
  localparam logic [4:0]        c_y_max = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(COLS * ROWS - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_op, r_param;
  logic [5:0]          r_x, w_x_nxt, w_bs_x;
  logic [4:0]          r_y, w_y_nxt, w_bs_y;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_disp_valid, r_cmd_err, w_err_nxt;
  logic                w_wr_req;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  // y*40 + x built from shifts, truncated to the RAM address width
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] ye, xe;
    ye = {{(ADDR_W-5){1'b0}}, y};
    xe = {{(ADDR_W-6){1'b0}}, x};
    return (ye << 5) + (ye << 3) + xe;
  endfunction

  always_comb begin
    w_bs_x = (r_x == 6'd0) ? c_x_max : r_x - 6'd1;
    w_bs_y = (r_x == 6'd0) ? r_y - 5'd1 : r_y;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_wr_req    = 1'b0;
    w_wr_addr   = cell_addr(r_x, r_y);
    w_wr_data   = '0;
    case (r_state)
      S_IDLE_OP:    if (cpu_valid) w_state_nxt = S_IDLE_PARAM;
      S_IDLE_PARAM: if (cpu_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_IDLE_OP;
        case (r_op)
          16'h00C0: begin
            if (r_param == 16'd0) w_state_nxt = S_CLEAR;
            else                  w_err_nxt   = 1'b1;
          end
          16'h00C1: begin
            w_wr_req  = 1'b1;
            w_wr_data = DATA_W'(r_param[7:0]);
            if (disp_req) begin
              w_state_nxt = S_EXEC;
            end else if (r_x == c_x_max) begin
              w_x_nxt = 6'd0;
              w_y_nxt = (r_y == c_y_max) ? 5'd0 : r_y + 5'd1;
            end else begin
              w_x_nxt = r_x + 6'd1;
            end
          end
          16'h00C2: begin
            if (r_x != 6'd0 || r_y != 5'd0) begin
              w_wr_req  = 1'b1;
              w_wr_addr = cell_addr(w_bs_x, w_bs_y);
              if (disp_req) begin
                w_state_nxt = S_EXEC;
              end else begin
                w_x_nxt = w_bs_x;
                w_y_nxt = w_bs_y;
              end
            end
          end
          16'h00C3: w_y_nxt = (r_param > 16'(ROWS - 1)) ? c_y_max : r_param[4:0];
          16'h00C4: w_x_nxt = (r_param > 16'(COLS - 1)) ? c_x_max : r_param[5:0];
          16'h00C5: w_state_nxt = S_CLEAR;
          16'h00C6: begin
            w_x_nxt = 6'd0;
            w_y_nxt = (r_y == c_y_max) ? 5'd0 : r_y + 5'd1;
          end
          default: w_err_nxt = 1'b1;
        endcase
      end
      S_CLEAR: begin
        w_wr_req  = 1'b1;
        w_wr_addr = r_cnt;
        // Sweep only advances on cycles the scanout leaves the port free
        if (!disp_req) begin
          if (r_cnt == c_last) begin
            w_cnt_nxt   = '0;
            w_x_nxt     = 6'd0;
            w_y_nxt     = 5'd0;
            w_state_nxt = S_IDLE_OP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE_OP;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= S_IDLE_OP;
      r_op         <= '0;
      r_param      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_disp_valid <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_cnt        <= w_cnt_nxt;
      r_disp_valid <= disp_req;
      r_cmd_err    <= w_err_nxt;
      if (r_state == S_IDLE_OP && cpu_valid)    r_op    <= cpu_data;
      if (r_state == S_IDLE_PARAM && cpu_valid) r_param <= cpu_data;
    end
  end

  // Scanout owns the port outright whenever it asks
  always_comb begin
    ram_en    = disp_req | w_wr_req;
    ram_we    = w_wr_req & ~disp_req;
    ram_addr  = disp_req ? disp_addr : w_wr_addr;
    ram_wdata = disp_req ? '0 : w_wr_data;
  end

  assign cpu_ready  = (r_state == S_IDLE_OP) || (r_state == S_IDLE_PARAM);
  assign busy       = (r_state == S_EXEC) || (r_state == S_CLEAR);
  assign disp_valid = r_disp_valid;
  assign disp_data  = ram_rdata;
  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign cmd_err    = r_cmd_err;

endmodule

`default_nettype wire

// File: doc/gpu_text_cmd_sequencer.md
Name: gpu_text_cmd_sequencer

Overview:
Sequences CPU text-mode commands into the 40x25 character RAM of the GPU and shares that single-port RAM with the VGA scanout.
- Accepts two-word commands (opcode word, then parameter word) over a valid/ready handshake.
- Maintains the text cursor and runs multi-cycle clear sweeps.
- Arbitrates RAM access: display reads have absolute priority over command writes.

Parameters:
COLS, 40, characters per row
ROWS, 25, text rows
ADDR_W, 10, character RAM address width (COLS*ROWS <= 2^ADDR_W)
DATA_W, 8, character code width

Ports:
clk  in  1  system clock; all logic on rising edge
clr  in  1  reset; asynchronous assert, active-low
cpu_data  in  16  command/parameter word from CPU
cpu_valid  in  1  cpu_data valid
cpu_ready  out  1  word accepted when cpu_valid && cpu_ready
disp_req  in  1  scanout read request, highest priority
disp_addr  in  ADDR_W  scanout cell address
disp_valid  out  1  disp_data valid, one cycle after disp_req
disp_data  out  DATA_W  character read for scanout
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle read latency
cursor_x  out  6  current column, 0..COLS-1
cursor_y  out  5  current row, 0..ROWS-1
busy  out  1  high in EXEC or CLEAR
cmd_err  out  1  one-cycle pulse on an unsupported opcode/mode

Behaviour:
- Reset (clr=0): state=IDLE_OP, cursor (0,0), disp_valid=0, cmd_err=0, ram_en/ram_we=0, clear counter=0.
  - Reset mid-clear aborts the sweep; RAM contents are then undefined.
- RAM port mux (combinational):
  - disp_req=1: ram_en=1, ram_we=0, ram_addr=disp_addr.
  - Otherwise the pending write, if any, drives the port.
  - disp_valid is registered disp_req; disp_data=ram_rdata.
- Cell address = y*40 + x, computed as (y<<5)+(y<<3)+x and truncated to ADDR_W bits.
- FSM states:
  - IDLE_OP: cpu_ready=1. An accepted word is latched as the opcode -> IDLE_PARAM.
  - IDLE_PARAM: cpu_ready=1. An accepted word is latched as the parameter -> EXEC.
  - EXEC: cpu_ready=0, executes the latched command (table below).
  - CLEAR: cpu_ready=0, sweep in progress.
- Command table (EXEC):
  - 0x00C0 mode, param 0: -> CLEAR. Param !=0 (graphics mode, unsupported): cmd_err pulse, no state change.
  - 0x00C1 put: write param[7:0] at the cursor, then advance. x=COLS-1 wraps to x=0, y+1; y=ROWS-1 wraps to y=0.
  - 0x00C2 backspace: cursor retreats one cell, then writes 0x00 at the new cell. x=0 goes to x=COLS-1, y-1. At (0,0) the command is a no-op: no write, cursor unchanged.
  - 0x00C3 set Y: y=min(param,ROWS-1). 0x00C4 set X: x=min(param,COLS-1). No RAM access.
  - 0x00C5 clear: -> CLEAR.
  - 0x00C6 newline: x=0, y+1; y=ROWS-1 goes to (0,0). No RAM access.
  - Any other opcode: parameter is consumed, cmd_err pulse, no effect.
- Completion: EXEC returns to IDLE_OP on the edge where its write is issued, or immediately for non-writing commands. The cursor updates on that same edge.
- Write stall: a pending write holds while disp_req=1. The opcode-to-write sequence has no upper bound under continuous disp_req.
- CLEAR sweep:
  - Writes 0x00 to addresses 0..COLS*ROWS-1, one per cycle with disp_req=0. The counter holds during display cycles.
  - After the last write: cursor (0,0) -> IDLE_OP.
  - Minimum duration is 1000 cycles.
- Latency with no display contention: parameter accepted at edge N; write asserted in cycle N+1; cpu_ready=1 again in cycle N+2.
- cpu_valid while cpu_ready=0 is ignored; the CPU must hold the word.
- Opcode compare uses all 16 bits. Only param[7:0] is stored by C1.

Test Plan:
- Reset, send C1/0x41 with disp_req=0 -> one write addr 0 data 0x41 in cycle N+1; cursor (1,0); cpu_ready=1 at N+2.
- Cursor (39,24), C1/0x5A -> write at addr 999; cursor wraps to (0,0).
- Cursor (0,1), C2/x -> write 0x00 at addr 39; cursor (39,0). At (0,0), C2 -> no write, cursor unchanged.
- C3/30 then C4/50 -> cursor (39,24), no RAM activity. C6 at y=24 -> cursor (0,0).
- C5 with disp_req toggling 50% -> exactly 1000 zero writes at addrs 0..999, none while disp_req=1; disp_valid follows disp_req by one cycle throughout.
- Opcode 0x1234, then C0/1 -> each consumes two words and pulses cmd_err once; pull clr low mid-clear -> state IDLE_OP, cursor (0,0), ram_we=0 immediately.
